jt12_kon_array: RTL and testbench
=================================

# jt12_kon_array

Parametrised key-on state block for the FM operator pipeline: holds the key-on bit of every operator slot in an addressable register array instead of a fixed-length delay line, so it serves channel counts other than six. It applies CPU key-on writes, CSM key-on from timer A overflow, and delivers the per-slot key state plus key-on/key-off edge pulses to the envelope generator. It sits between the register interface (`up_keyon`, `keyon_ch`, `keyon_op`) and the envelope generator, indexed by the slot counter (`cur_ch`, `cur_op`).

## Interface

- `CHW`, 3: channel code width; state array holds 4·2^CHW bits.
- `CSM_CH`, 3'd2: channel code that CSM key-on applies to.
- `clk`  in  1  system clock; all state advances only when `clk_en`=1.
- `rst`  in  1  reset, asynchronous, active-high.
- `clk_en`  in  1  slot advance enable.
- `cur_ch`  in  CHW  channel code of the current slot.
- `cur_op`  in  2  operator of the current slot, in slot order S1,S3,S2,S4 (codes 0..3).
- `keyon_ch`  in  CHW  channel addressed by the key-on register write.
- `keyon_op`  in  4  key-on bits {S4,S3,S2,S1}.
- `up_keyon`  in  1  key-on register write pending.
- `csm`  in  1  CSM mode active.
- `overflow_A`  in  1  timer A overflow strobe.
- `status_ch`  in  CHW  channel selected for status readback.
- `keyon_I`  out  1  key state of the previous `clk_en` slot; reset 0.
- `kon_edge`  out  1  off→on transition for that slot; reset 0.
- `koff_edge`  out  1  on→off transition for that slot; reset 0.
- `status_op`  out  4  stored key bits {S4,S3,S2,S1} of `status_ch`; reset 0.

## Operation

- Slot index is {`cur_ch`,`cur_op`}. Operator bit mapping: `cur_op` 0→`keyon_op[0]`, 1→`keyon_op[2]`, 2→`keyon_op[1]`, 3→`keyon_op[3]`.
- Key array `kreg`: one bit per slot. On a `clk_en` cycle with `up_keyon`=1 and `keyon_ch`==`cur_ch`, `kreg[slot]` is loaded with the mapped `keyon_op` bit. `up_keyon` is held by the register interface for a full sweep. Otherwise `kreg` holds.
- CSM capture: `overflow_A`=1 on a `clk_en` cycle sets `ovf_pend` and records the current slot in `ovf_slot`. A later `overflow_A` re-records the slot.
- `ovf_pend` clears on the first `clk_en` cycle without `overflow_A` where the current slot equals `ovf_slot`. It therefore lasts exactly one full sweep of 4·2^CHW slots.
- Effective key: `eff = kreg_next[slot] | (csm & cur_ch==CSM_CH & ovf_pend)`.
  - `kreg_next` is the value written this cycle if a write hits the slot; otherwise it is the stored value. The write takes priority over the read.
  - CSM forcing does not modify `kreg`.
- Previous-state array `pst`: one bit per slot, updated with `eff` each `clk_en`.
  - `kon_edge` = `eff & ~pst[slot]`.
  - `koff_edge` = `~eff & pst[slot]`.
  - Both edge outputs are registered alongside `keyon_I`.
- Channel codes with no physical channel (e.g. 3, 7 at six channels) are stored normally. Downstream ignores them.

## Timing

- Latency: `keyon_I`, `kon_edge` and `koff_edge` update on the `clk_en` edge that samples the slot. They hold until the next `clk_en`.
- `clk_en`=0: no state or output changes.
- `rst` asserted at any time: immediately clears `kreg`, `pst`, `ovf_pend`, `ovf_slot` and all outputs to 0. After release, the first `clk_en` slot sees all keys off.
- `overflow_A` together with a match on `ovf_slot`: set wins, and the slot is re-recorded.
- `status_op` is registered and updated every `clk` cycle (not gated by `clk_en`). It reflects `kreg` only, never CSM forcing.

## Configuration

- `JT12_KON_STATUS_EN` defined: the `status_op` readback logic is built as described.
- `JT12_KON_STATUS_EN` undefined: `status_op` is tied to 4'b0 and `status_ch` is ignored. The port list is unchanged, and `keyon_I`/edge behaviour is identical.

## Test plan

- Reset, then sweep all slots with no writes → `keyon_I`, `kon_edge`, `koff_edge` = 0 on every slot.
- `keyon_ch`=1, `keyon_op`=4'b0101, `up_keyon` held for one sweep → first visit of ch1:
  - `cur_op`=0 and `cur_op`=1 give `keyon_I`=1, `kon_edge`=1.
  - `cur_op`=2 and `cur_op`=3 give 0.
  - Next sweep: `keyon_I`=1 with `kon_edge`=0.
- Then write `keyon_op`=0 to ch1 → one `koff_edge` pulse each on ch1 `cur_op` 0 and 1 only.
- `csm`=1, `overflow_A` pulsed at slot {5,3} with `kreg` all 0 →
  - All four ch2 slots give `keyon_I`=1 on the next sweep.
  - The following sweep gives `koff_edge`=1 on each.
  - With `csm`=0, no response.
- Write to the slot being read in the same `clk_en` cycle → `keyon_I` equals the new value (write-first).
- Assert `rst` mid-sweep with keys on → outputs 0 immediately. After release, keys are off and no `koff_edge` is produced. With `JT12_KON_STATUS_EN` defined, `status_ch`=1 after the 4'b0101 write gives `status_op`=4'b0101; undefined, it gives 4'b0.

Source files
------------

// File: rtl/jt12_kon_array_if.sv
// Key-on block interface: register-side key-on writes, slot counter, CSM controls, key-state outputs.
// Latency: none, wiring only.
// Backpressure: none; the slot stream advances on clk_en and cannot be stalled.
interface jt12_kon_array_if #(
    parameter int CHW = 3
);
    logic           clk_en;
    logic [CHW-1:0] cur_ch;
    logic [1:0]     cur_op;
    logic [CHW-1:0] keyon_ch;
    logic [3:0]     keyon_op;
    logic           up_keyon;
    logic           csm;
    logic           overflow_A;
    logic [CHW-1:0] status_ch;
    logic           keyon_I;
    logic           kon_edge;
    logic           koff_edge;
    logic [3:0]     status_op;

    // Driver side: register interface, slot counter and timer.
    modport master (
        output clk_en, cur_ch, cur_op, keyon_ch, keyon_op, up_keyon,
               csm, overflow_A, status_ch,
        input  keyon_I, kon_edge, koff_edge, status_op
    );

    // Key-on block side.
    modport slave (
        input  clk_en, cur_ch, cur_op, keyon_ch, keyon_op, up_keyon,
               csm, overflow_A, status_ch,
        output keyon_I, kon_edge, koff_edge, status_op
    );
endinterface

// File: rtl/jt12_kon_array.sv
// Per-slot key-on state array with CPU writes, CSM key-on from timer A, and key edge pulses.
// Latency: key state and edges are registered on the clk_en edge that samples the slot; status_op 1 clk.
// Backpressure: none; optional status readback is built only when JT12_KON_STATUS_EN is defined.
module jt12_kon_array #(
    parameter int             CHW    = 3,
    parameter logic [CHW-1:0] CSM_CH = CHW'(2)
) (
    input logic                clk,
    input logic                rst,
    jt12_kon_array_if.slave    bus
);
    localparam int SW    = CHW + 2;
    localparam int NSLOT = 4 << CHW;

    logic [NSLOT-1:0] r_kreg;
    logic [NSLOT-1:0] r_pst;
    logic             r_ovf_pend;
    logic [SW-1:0]    r_ovf_slot;
    logic             r_keyon_I;
    logic             r_kon_edge;
    logic             r_koff_edge;
    logic [3:0]       r_status_op;

    logic [SW-1:0]    w_slot;
    logic             w_wbit;
    logic             w_hit;
    logic             w_kreg_next;
    logic             w_csm_force;
    logic             w_eff;
    logic             w_pst;

    assign w_slot      = {bus.cur_ch, bus.cur_op};
    assign w_hit       = bus.up_keyon && (bus.keyon_ch == bus.cur_ch);
    // A write hitting the slot being read wins over the stored bit.
    assign w_kreg_next = w_hit ? w_wbit : r_kreg[w_slot];
    assign w_csm_force = bus.csm && (bus.cur_ch == CSM_CH) && r_ovf_pend;
    assign w_eff       = w_kreg_next | w_csm_force;
    assign w_pst       = r_pst[w_slot];

    // Slot order is S1,S3,S2,S4 while the key-on byte is {S4,S3,S2,S1}.
    always_comb begin
        w_wbit = 1'b0;
        case (bus.cur_op)
            2'd0:    w_wbit = bus.keyon_op[0];
            2'd1:    w_wbit = bus.keyon_op[2];
            2'd2:    w_wbit = bus.keyon_op[1];
            default: w_wbit = bus.keyon_op[3];
        endcase
    end

    // Slot-rate state: key array, previous-state array, CSM capture and key outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kreg      <= '0;
            r_pst       <= '0;
            r_ovf_pend  <= 1'b0;
            r_ovf_slot  <= '0;
            r_keyon_I   <= 1'b0;
            r_kon_edge  <= 1'b0;
            r_koff_edge <= 1'b0;
        end else if (bus.clk_en) begin
            if (w_hit) begin
                r_kreg[w_slot] <= w_wbit;
            end
            r_pst[w_slot] <= w_eff;
            r_keyon_I     <= w_eff;
            r_kon_edge    <= w_eff & ~w_pst;
            r_koff_edge   <= ~w_eff & w_pst;
            // A new overflow re-arms the window; otherwise it closes one sweep after capture.
            if (bus.overflow_A) begin
                r_ovf_pend <= 1'b1;
                r_ovf_slot <= w_slot;
            end else if (w_slot == r_ovf_slot) begin
                r_ovf_pend <= 1'b0;
            end
        end
    end

`ifdef JT12_KON_STATUS_EN
    // Status readback of the stored key bits, repacked to {S4,S3,S2,S1}; CSM forcing is not visible here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status_op <= 4'b0;
        end else begin
            r_status_op <= {r_kreg[{bus.status_ch, 2'd3}],
                            r_kreg[{bus.status_ch, 2'd1}],
                            r_kreg[{bus.status_ch, 2'd2}],
                            r_kreg[{bus.status_ch, 2'd0}]};
        end
    end
`else
    logic w_unused_status;
    assign w_unused_status = ^bus.status_ch;
    assign r_status_op     = 4'b0;
`endif

    assign bus.keyon_I   = r_keyon_I;
    assign bus.kon_edge  = r_kon_edge;
    assign bus.koff_edge = r_koff_edge;
    assign bus.status_op = r_status_op;
endmodule

// File: tb/tb_jt12_kon_array.sv
// Directed bench for jt12_kon_array: slot sweeps with hand-computed key/edge expectations.
// Latency: outputs sampled 1 time unit after each clk_en edge.
// Backpressure: none; runs a fixed number of cycles.
module tb_jt12_kon_array;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    jt12_kon_array_if #(.CHW(3)) bus ();

    jt12_kon_array #(.CHW(3), .CSM_CH(3'd2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk_en slot; outputs are sampled shortly after the edge.
    task automatic step(input int ch, input int op);
        bus.cur_ch = 3'(ch);
        bus.cur_op = 2'(op);
        @(posedge clk);
        #1;
    endtask

    // Full sweep of 32 slots. Channel xch gets the {keyon_I,kon,koff} triples packed as
    // {op3,op2,op1,op0} in xexp; every other slot must read 000. overflow_A pulses at ovf_at.
    task automatic sweep(input string tag, input int xch, input logic [11:0] xexp, input int ovf_at);
        logic [2:0] exp3;
        for (int ch = 0; ch < 8; ch++) begin
            for (int op = 0; op < 4; op++) begin
                bus.overflow_A = ((ch * 4 + op) == ovf_at);
                step(ch, op);
                exp3 = (ch == xch) ? xexp[op*3 +: 3] : 3'b000;
                check($sformatf("%s ch%0d op%0d", tag, ch, op),
                      {29'd0, bus.keyon_I, bus.kon_edge, bus.koff_edge}, {29'd0, exp3});
            end
        end
        bus.overflow_A = 1'b0;
    endtask

    logic [3:0] exp_status;

    initial begin
`ifdef JT12_KON_STATUS_EN
        exp_status = 4'b0101;
`else
        exp_status = 4'b0000;
`endif
        bus.clk_en     = 1'b1;
        bus.cur_ch     = '0;
        bus.cur_op     = '0;
        bus.keyon_ch   = '0;
        bus.keyon_op   = '0;
        bus.up_keyon   = 1'b0;
        bus.csm        = 1'b0;
        bus.overflow_A = 1'b0;
        bus.status_ch  = 3'd1;

        // Reset state
        #2;
        check("rst keyon_I",   {31'd0, bus.keyon_I},   0);
        check("rst kon_edge",  {31'd0, bus.kon_edge},  0);
        check("rst koff_edge", {31'd0, bus.koff_edge}, 0);
        check("rst status_op", {28'd0, bus.status_op}, 0);
        @(negedge clk);
        rst = 1'b0;

        sweep("idle", -1, 12'b0, -1);

        // Key on S1,S3 of ch1; write lands on the slot being read.
        bus.keyon_ch = 3'd1;
        bus.keyon_op = 4'b0101;
        bus.up_keyon = 1'b1;
        sweep("kon", 1, 12'b000_000_110_110, -1);
        bus.up_keyon = 1'b0;
        @(posedge clk); #1;
        check("status ch1", {28'd0, bus.status_op}, {28'd0, exp_status});
        sweep("hold", 1, 12'b000_000_100_100, -1);

        // Key off ch1
        bus.keyon_op = 4'b0000;
        bus.up_keyon = 1'b1;
        sweep("koff", 1, 12'b000_000_001_001, -1);
        bus.up_keyon = 1'b0;

        // CSM key-on: overflow at slot {5,3}
        bus.csm = 1'b1;
        sweep("csm ovf",  -1, 12'b0, 5 * 4 + 3);
        sweep("csm on",    2, 12'b110_110_110_110, -1);
        sweep("csm off",   2, 12'b001_001_001_001, -1);
        sweep("csm quiet", -1, 12'b0, -1);
        bus.csm = 1'b0;
        sweep("nocsm ovf", -1, 12'b0, 5 * 4 + 3);
        sweep("nocsm",     -1, 12'b0, -1);

        // Write-first on a single slot
        bus.keyon_ch = 3'd4;
        bus.keyon_op = 4'b1000;
        bus.up_keyon = 1'b1;
        step(4, 3);
        check("wf on", {29'd0, bus.keyon_I, bus.kon_edge, bus.koff_edge}, 32'b110);
        bus.keyon_op = 4'b0000;
        step(4, 3);
        check("wf off", {29'd0, bus.keyon_I, bus.kon_edge, bus.koff_edge}, 32'b001);
        bus.up_keyon = 1'b0;

        // Reset mid-sweep with keys on
        bus.keyon_ch = 3'd1;
        bus.keyon_op = 4'b0101;
        bus.up_keyon = 1'b1;
        sweep("kon2", 1, 12'b000_000_110_110, -1);
        bus.up_keyon = 1'b0;
        for (int op = 0; op < 4; op++) step(0, op);
        step(1, 0);
        check("pre-rst keyon_I", {31'd0, bus.keyon_I}, 1);
        check("pre-rst status",  {28'd0, bus.status_op}, {28'd0, exp_status});
        rst = 1'b1;
        #1;
        check("mid-rst keyon_I",   {31'd0, bus.keyon_I},   0);
        check("mid-rst kon_edge",  {31'd0, bus.kon_edge},  0);
        check("mid-rst koff_edge", {31'd0, bus.koff_edge}, 0);
        check("mid-rst status",    {28'd0, bus.status_op}, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep("post-rst", -1, 12'b0, -1);
        check("post-rst status", {28'd0, bus.status_op}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
